// File: rtl/decode_pkg.sv
// Shared definitions for the pipelined RV32I/RV64I decode unit.
package decode_pkg;

  // Internal packet width; the top truncates pc/immed to XLEN.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IT_R   = 3'd0,
    IT_I   = 3'd1,
    IT_S   = 3'd2,
    IT_SB  = 3'd3,
    IT_U   = 3'd4,
    IT_UJ  = 3'd5,
    IT_ILL = 3'd7
  } itype_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [XLEN_MAX-1:0] immed;
    itype_e              itype;
    logic                illegal;
  } dec_pkt_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: type, fields, immediate, illegal flag.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FUNC7_STRICT = 1'b1
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output dec_pkt_t        pkt_o
);

  itype_e     itype;
  logic [6:0] opcode;
  logic       func7_ok;

  assign opcode   = instr_i[6:0];
  assign func7_ok = (instr_i[31:25] == 7'h00) || (instr_i[31:25] == 7'h20);

  // Classify the instruction format from the full 7-bit opcode.
  always_comb begin
    itype = IT_ILL;
    case (opcode)
      OP_R:                       itype = IT_R;
      OP_IMM, OP_LOAD, OP_JALR:   itype = IT_I;
      OP_STORE:                   itype = IT_S;
      OP_BRANCH:                  itype = IT_SB;
      OP_LUI, OP_AUIPC:           itype = IT_U;
      OP_JAL:                     itype = IT_UJ;
      default:                    itype = IT_ILL;
    endcase
  end

  // Build the packet: zero fields a format does not use, sign-extend immediates.
  always_comb begin
    pkt_o         = '0;
    pkt_o.pc      = XLEN_MAX'(pc_i);
    pkt_o.opcode  = opcode;
    pkt_o.func3   = instr_i[14:12];
    pkt_o.itype   = itype;
    pkt_o.rs1     = instr_i[19:15];
    pkt_o.rs2     = instr_i[24:20];
    pkt_o.rd      = instr_i[11:7];
    pkt_o.illegal = (itype == IT_ILL) || (instr_i[1:0] != 2'b11) ||
                    (FUNC7_STRICT && (itype == IT_R) && !func7_ok);

    if (itype == IT_I || itype == IT_U || itype == IT_UJ || itype == IT_ILL)
      pkt_o.rs2 = 5'd0;
    if (itype == IT_U || itype == IT_UJ)
      pkt_o.rs1 = 5'd0;
    if (itype == IT_S || itype == IT_SB)
      pkt_o.rd = 5'd0;

    // Shift-immediate forms carry func7 (srai vs srli) in the upper bits.
    if (itype == IT_R ||
        (opcode == OP_IMM && (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101)))
      pkt_o.func7 = instr_i[31:25];

    case (itype)
      IT_I:  pkt_o.immed = {{52{instr_i[31]}}, instr_i[31:20]};
      IT_S:  pkt_o.immed = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IT_SB: pkt_o.immed = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
      IT_U:  pkt_o.immed = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
      IT_UJ: pkt_o.immed = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
      default: pkt_o.immed = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit_pipe.sv
// Pipelined decode stage: output register plus one skid entry.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a valid packet is held stable until accepted, and ready_o is a register
// so there is no combinational path from ready_i to ready_o.
module decode_unit_pipe
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FUNC7_STRICT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      RS1_o,
  output logic [4:0]      RS2_o,
  output logic [4:0]      RD_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      func3_o,
  output logic [6:0]      func7_o,
  output logic [XLEN-1:0] immed_o,
  output logic [2:0]      itype_o,
  output logic            illegal_o
);

  dec_pkt_t dec_pkt;
  dec_pkt_t out_q, out_d;
  dec_pkt_t skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     ready_q;
  logic     accept;

  decode_comb #(
    .XLEN         (XLEN),
    .FUNC7_STRICT (FUNC7_STRICT)
  ) u_decode_comb (
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .pkt_o   (dec_pkt)
  );

  assign accept = valid_i && ready_q;

  // Next state of output and skid registers: flush beats drain beats fill.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d = dec_pkt;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q && accept) begin
      out_d       = dec_pkt;
      out_valid_d = 1'b1;
    end else if (out_valid_q && !ready_i && accept) begin
      skid_d       = dec_pkt;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset drops any held packets and clears the data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = out_valid_q;
  assign pc_o      = out_q.pc[XLEN-1:0];
  assign RS1_o     = out_q.rs1;
  assign RS2_o     = out_q.rs2;
  assign RD_o      = out_q.rd;
  assign opcode_o  = out_q.opcode;
  assign func3_o   = out_q.func3;
  assign func7_o   = out_q.func7;
  assign immed_o   = out_q.immed[XLEN-1:0];
  assign itype_o   = out_q.itype;
  assign illegal_o = out_q.illegal;

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.pc[XLEN_MAX-1:XLEN], out_q.immed[XLEN_MAX-1:XLEN]};
  end

endmodule
